// File: rtl/alu_pipe_pkg.sv
// Shared types for alu_pipe: opcode encoding, multiplier FSM states and result flags.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1010
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational op and flag evaluation for alu_pipe; MUL is not handled here
// and decodes as an invalid op.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output flags_t           flags_o
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic [WIDTH:0]         sum;
  logic [WIDTH:0]         diff;
  logic [SHAMT_W-1:0]     shamt;

  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shamt = b_i[SHAMT_W-1:0];

  always_comb begin
    result_o      = '0;
    flags_o       = '0;
    case (op_i)
      OP_ADD: begin
        result_o      = sum[WIDTH-1:0];
        flags_o.carry = sum[WIDTH];
        flags_o.ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        // The WIDTH+1 subtraction's top bit is exactly the unsigned borrow.
        result_o      = diff[WIDTH-1:0];
        flags_o.carry = diff[WIDTH];
        flags_o.ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default: flags_o.err = 1'b1;
    endcase
    flags_o.zero = (result_o == '0);
    flags_o.neg  = result_o[WIDTH-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake on both sides and one output stage.
// Define ALU_PIPE_MUL_EN to add the iterative shift-add multiplier (op 1010).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_err
);

  logic [WIDTH-1:0] core_res;
  flags_t           core_flags;
  state_e           state_q;
  logic             accept;
  logic             is_mul_op;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  flags_t           flags_q, flags_d;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (in_a),
    .b_i      (in_b),
    .op_i     (in_op),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  assign in_ready = (state_q == ST_IDLE) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e           state_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign is_mul_op = (in_op == OP_MUL);
  assign mul_res   = acc_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_mul_op) state_d = ST_MUL;
      ST_MUL:  if (mul_done)            state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The product waits in acc_q if the output register still holds an unconsumed result.
  always_comb begin
    mul_done = (state_q == ST_MUL) && (cnt_q == CNT_W'(WIDTH)) && (!valid_q || out_ready);
  end

  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (accept) begin
      mul_a_d = in_a;
      mul_b_d = in_b;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_MUL && cnt_q != CNT_W'(WIDTH)) begin
      acc_d   = acc_q + (mul_b_q[0] ? mul_a_q : '0);
      mul_a_d = mul_a_q << 1;
      mul_b_d = mul_b_q >> 1;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign state_q   = ST_IDLE;
  assign is_mul_op = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
`endif

  always_comb begin
    valid_d = valid_q && !out_ready;
    res_d   = res_q;
    flags_d = flags_q;
    if (mul_done) begin
      res_d        = mul_res;
      flags_d      = '0;
      flags_d.zero = (mul_res == '0);
      flags_d.neg  = mul_res[WIDTH-1];
      valid_d      = 1'b1;
    end else if (accept && !is_mul_op) begin
      res_d   = core_res;
      flags_d = core_flags;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_zero   = flags_q.zero;
  assign out_neg    = flags_q.neg;
  assign out_carry  = flags_q.carry;
  assign out_ovf    = flags_q.ovf;
  assign out_err    = flags_q.err;

endmodule
